// File: rtl/cache_pkg.sv
// Shared geometry, AXI encodings and FSM state encoding for the cache line refill engine.
package cache_pkg;

    localparam int CACHE_LINE_WIDTH = 6;
    localparam int TAG_WIDTH        = 20;
    localparam int OFFSET_WIDTH     = CACHE_LINE_WIDTH - 2;
    localparam int WORDS            = 1 << OFFSET_WIDTH;
    localparam int INDEX_WIDTH      = 32 - TAG_WIDTH - CACHE_LINE_WIDTH;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LINE_LEN   = 8'(WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_AW,
        ST_WB_RD,
        ST_WB_W,
        ST_WB_B,
        ST_RF_AR,
        ST_RF_R,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cache_wb_buffer.sv
// Two-entry read-ahead buffer for writeback; entries land one cycle after issue_i (storage latency).
// Head bypasses the storage read port when empty, so a read issued last cycle can be consumed at once.
`ifdef CACHE_WB_PREFETCH_EN
module cache_wb_buffer #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_i,
    input  logic [DW-1:0] rdata_i,
    input  logic          pop_i,
    output logic          vld_o,
    output logic [DW-1:0] dat_o,
    output logic [1:0]    occ_o
);

    logic          pend_q;
    logic          wptr_q;
    logic          rptr_q;
    logic [1:0]    cnt_q;
    logic [DW-1:0] mem_q [2];
    logic          push;
    logic          deq;

    assign vld_o = (cnt_q != 2'd0) || pend_q;
    assign dat_o = (cnt_q != 2'd0) ? mem_q[rptr_q] : rdata_i;
    assign occ_o = cnt_q + {1'b0, pend_q};

    // A pending word consumed straight from the storage port never enters the entries.
    assign push = pend_q && !((cnt_q == 2'd0) && pop_i);
    assign deq  = pop_i && (cnt_q != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            pend_q <= issue_i;
            if (push) wptr_q <= ~wptr_q;
            if (deq)  rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= rdata_i;
    end

endmodule
`endif

// File: rtl/cache_line_refill.sv
// Miss engine: optional dirty-victim AXI writeback, then AXI line refill into line storage; done pulses after last word.
// CACHE_WB_PREFETCH_EN: read-ahead buffer gives 1 writeback beat/cycle (else 2 cycles/beat); all AXI phases wait on ready/valid.
module cache_line_refill
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic                    victim_dirty,
    input  logic [TAG_WIDTH-1:0]    victim_tag,
    output logic                    done,
    output logic                    err,
    output logic                    line_we,
    output logic [OFFSET_WIDTH-1:0] line_woff,
    output logic [31:0]             line_wdata,
    output logic [3:0]              line_wbe,
    output logic [TAG_WIDTH-1:0]    line_wtag,
    output logic                    line_wdirty,
    output logic                    line_wvalid,
    output logic [OFFSET_WIDTH-1:0] line_roff,
    input  logic [31:0]             line_rdata,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = '1;

    state_e                            state_q, state_d;
    logic [OFFSET_WIDTH-1:0]           beat_q, beat_d;
    logic [31:CACHE_LINE_WIDTH]        addr_q, addr_d;
    logic [TAG_WIDTH-1:0]              vtag_q, vtag_d;
    logic                              err_q, err_d;
    logic                              req_ready_raw;
    logic                              unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[CACHE_LINE_WIDTH-1:0];

    assign arid    = 4'd0;
    assign arlen   = AXI_LINE_LEN;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign araddr  = {addr_q, {CACHE_LINE_WIDTH{1'b0}}};
    assign awid    = 4'd0;
    assign awlen   = AXI_LINE_LEN;
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign awaddr  = {vtag_q, addr_q[CACHE_LINE_WIDTH +: INDEX_WIDTH], {CACHE_LINE_WIDTH{1'b0}}};
    assign wstrb   = 4'hF;

    assign line_woff   = beat_q;
    assign line_wdata  = rdata;
    assign line_wbe    = 4'hF;
    assign line_wtag   = addr_q[31 -: TAG_WIDTH];
    assign line_wdirty = 1'b0;

    // Held low while reset is asserted so upstream never sees a ready from a resetting engine.
    assign req_ready = req_ready_raw && !rst;
    assign err       = (state_q == ST_DONE) && err_q;

`ifdef CACHE_WB_PREFETCH_EN
    logic [OFFSET_WIDTH:0] rptr_q, rptr_d;
    logic                  issue;
    logic                  pop;
    logic                  buf_vld;
    logic [31:0]           buf_dat;
    logic [1:0]            buf_occ;

    cache_wb_buffer #(.DW(32)) u_wb_buffer (
        .clk     (clk),
        .rst     (rst),
        .issue_i (issue),
        .rdata_i (line_rdata),
        .pop_i   (pop),
        .vld_o   (buf_vld),
        .dat_o   (buf_dat),
        .occ_o   (buf_occ)
    );

    assign line_roff = rptr_q[OFFSET_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rptr_q <= '0;
        else     rptr_q <= rptr_d;
    end
`else
    assign line_roff = beat_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            vtag_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            vtag_q  <= vtag_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        addr_d        = addr_q;
        vtag_d        = vtag_q;
        err_d         = err_q;
        req_ready_raw = 1'b0;
        done          = 1'b0;
        line_we       = 1'b0;
        line_wvalid   = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        wdata         = line_rdata;
        wlast         = 1'b0;
        bready        = 1'b0;
`ifdef CACHE_WB_PREFETCH_EN
        rptr_d        = rptr_q;
        issue         = 1'b0;
        pop           = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                req_ready_raw = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr[31:CACHE_LINE_WIDTH];
                    vtag_d  = victim_tag;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = victim_dirty ? ST_WB_AW : ST_RF_AR;
`ifdef CACHE_WB_PREFETCH_EN
                    rptr_d  = '0;
`endif
                end
            end
            ST_WB_AW: begin
                awvalid = 1'b1;
                if (awready) state_d = ST_WB_RD;
            end
            ST_WB_RD: begin
                state_d = ST_WB_W;
`ifdef CACHE_WB_PREFETCH_EN
                issue  = 1'b1;
                rptr_d = rptr_q + 1'b1;
`endif
            end
            ST_WB_W: begin
                wlast = (beat_q == LAST_BEAT);
`ifdef CACHE_WB_PREFETCH_EN
                wvalid = buf_vld;
                wdata  = buf_dat;
                pop    = buf_vld && wready;
                // Keep at most two words in flight between storage and the W channel.
                issue  = !rptr_q[OFFSET_WIDTH] && ((buf_occ < 2'd2) || pop);
                if (issue) rptr_d = rptr_q + 1'b1;
                if (pop) begin
                    beat_d = beat_q + 1'b1;
                    if (wlast) state_d = ST_WB_B;
                end
`else
                wvalid = 1'b1;
                if (wready) begin
                    beat_d  = beat_q + 1'b1;
                    state_d = wlast ? ST_WB_B : ST_WB_RD;
                end
`endif
            end
            ST_WB_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    if (bresp != AXI_RESP_OKAY) err_d = 1'b1;
                    beat_d  = '0;
                    state_d = ST_RF_AR;
                end
            end
            ST_RF_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = ST_RF_R;
            end
            ST_RF_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    line_we     = 1'b1;
                    line_wvalid = (beat_q == LAST_BEAT);
                    if ((rresp != AXI_RESP_OKAY) || (rlast != (beat_q == LAST_BEAT))) err_d = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench for cache_line_refill: clean/dirty misses, W stall, R error responses, reset mid-writeback.
module tb_cache_line_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        victim_dirty;
    logic [19:0] victim_tag;
    logic        done, err;
    logic        line_we;
    logic [3:0]  line_woff;
    logic [31:0] line_wdata;
    logic [3:0]  line_wbe;
    logic [19:0] line_wtag;
    logic        line_wdirty, line_wvalid;
    logic [3:0]  line_roff;
    logic [31:0] line_rdata;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    logic [31:0] mem [16];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) line_rdata <= mem[line_roff];

    cache_line_refill dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .done(done), .err(err),
        .line_we(line_we), .line_woff(line_woff), .line_wdata(line_wdata), .line_wbe(line_wbe),
        .line_wtag(line_wtag), .line_wdirty(line_wdirty), .line_wvalid(line_wvalid),
        .line_roff(line_roff), .line_rdata(line_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return awvalid;
            1:       return bready;
            2:       return arvalid;
            default: return wvalid;
        endcase
    endfunction

    task automatic wait_hi(input int which, input string tag);
        int n = 0;
        while (sel(which) !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, {31'b0, sel(which)}, 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {23'b0, awvalid, wvalid, bready, arvalid, rready, line_we, done, req_ready, err}, 32'd0);
        check({tag, "_roff"}, {28'b0, line_roff}, 32'd0);
    endtask

    task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [19:0] vtag,
                            input logic [31:0] exp_aw, input logic [31:0] exp_ar, input logic [19:0] exp_tag,
                            input int stall_beat, input int rerr_beat, input int rlast_beat,
                            input int rst_beat, input logic exp_err);
        int k;
        int stalls;
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; victim_dirty = dirty; victim_tag = vtag;
        #1;
        check("req_ready", req_ready, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("req_ready_busy", req_ready, 32'd0);
        if (dirty) begin
            wait_hi(0, "awvalid");
            check("awaddr", awaddr, exp_aw);
            check("awlen", awlen, 32'd15);
            awready = 1'b1;
            @(negedge clk);
            awready = 1'b0;
            k = 0; stalls = 0; guard = 0;
            while (k < 16 && guard < 300) begin
                #1;
                guard++;
                if (wvalid) begin
                    check("wdata", wdata, k * 32'h1111_1111);
                    check("wlast", wlast, (k == 15));
                    if (k == rst_beat) begin
                        rst = 1'b1;
                        #1;
                        check_quiet("rst_mid");
                        @(negedge clk);
                        rst = 1'b0;
                        #1;
                        check("req_ready_after_rst", req_ready, 32'd1);
                        return;
                    end
                    wready = !(k == stall_beat && stalls < 5);
                    if (!wready) stalls++;
                    @(posedge clk);
                    if (wready) k++;
                end else begin
                    @(posedge clk);
                end
                @(negedge clk);
                wready = 1'b0;
            end
            check("w_beats", k, 32'd16);
            #1;
            wait_hi(1, "bready");
            bvalid = 1'b1; bresp = 2'b00;
            @(negedge clk);
            bvalid = 1'b0;
            #1;
        end
        wait_hi(2, "arvalid");
        check("araddr", araddr, exp_ar);
        check("arlen", arlen, 32'd15);
        check("arsize_burst", {27'b0, arsize, arburst}, {27'b0, 3'd2, 2'b01});
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            rvalid = 1'b1;
            rdata  = 32'hC0DE_0000 + b;
            rresp  = (b == rerr_beat) ? 2'b10 : 2'b00;
            rlast  = (b == rlast_beat);
            #1;
            check("line_we", line_we, 32'd1);
            check("line_woff", line_woff, b);
            check("line_wdata", line_wdata, 32'hC0DE_0000 + b);
            check("line_wvalid", line_wvalid, (b == 15));
            check("done_early", done, 32'd0);
            if (b == 0) begin
                check("line_wtag", line_wtag, exp_tag);
                check("line_wbe_dirty", {27'b0, line_wbe, line_wdirty}, {27'b0, 4'hF, 1'b0});
            end
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        #1;
        check("done", done, 32'd1);
        check("err", err, exp_err);
        check("line_we_done", line_we, 32'd0);
        @(negedge clk);
        #1;
        check("done_pulse", done, 32'd0);
        check("req_ready_idle", req_ready, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = i * 32'h1111_1111;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; victim_dirty = 1'b0; victim_tag = '0;
        arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        #1;
        check_quiet("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_req_ready", req_ready, 32'd1);
        check("reset_done", done, 32'd0);

        // Clean miss
        run_miss(32'h1234_5678, 1'b0, 20'h0, 32'h0, 32'h1234_5640, 20'h12345, -1, -1, 15, -1, 1'b0);
        // Dirty miss with a 5-cycle wready stall on beat 3
        run_miss(32'h0000_0FC0, 1'b1, 20'hABCDE, 32'hABCD_EFC0, 32'h0000_0FC0, 20'h00000, 3, -1, 15, -1, 1'b0);
        // SLVERR on refill beat 7
        run_miss(32'h8000_0004, 1'b0, 20'h0, 32'h0, 32'h8000_0000, 20'h80000, -1, 7, 15, -1, 1'b1);
        // Early rlast on beat 9
        run_miss(32'h4444_4480, 1'b0, 20'h0, 32'h0, 32'h4444_4480, 20'h44444, -1, -1, 9, -1, 1'b1);
        // Reset during writeback beat 4, then a normal request
        run_miss(32'h0000_0FC0, 1'b1, 20'hABCDE, 32'hABCD_EFC0, 32'h0000_0FC0, 20'h00000, -1, -1, 15, 4, 1'b0);
        run_miss(32'hDEAD_BEEF, 1'b0, 20'h0, 32'h0, 32'hDEAD_BEC0, 20'hDEADB, -1, -1, 15, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_line_refill.md
Name: cache_line_refill

Overview:
- Miss-handling engine for one cache set.
- On a miss it writes back a dirty victim line over an AXI write burst, then refills the line over an AXI read burst.
- During refill it drives the cache line storage write port word by word (we/woff/wdata/byte-enable/tag/dirty/valid).
- Sits between the cache hit/miss logic (upstream) and the cache line storage plus the AXI master port (downstream).

Parameters:
- CACHE_LINE_WIDTH, 6, log2 of line size in bytes (max 64 B = 16 words).
- TAG_WIDTH, 20, tag bits of the physical address.
- OFFSET_WIDTH, CACHE_LINE_WIDTH-2, word-offset bits; WORDS = 2**OFFSET_WIDTH.
- INDEX_WIDTH, 32-TAG_WIDTH-CACHE_LINE_WIDTH, set-index bits.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  miss request.
- req_ready  out  1  high only in IDLE.
- req_addr  in  32  missing physical address.
- victim_dirty  in  1  victim line needs writeback.
- victim_tag  in  TAG_WIDTH  tag of the victim line.
- done  out  1  one-cycle pulse when the line has been refilled.
- err  out  1  valid with done; any non-OKAY response or rlast mismatch.
- line_we  out  1  cache line write enable.
- line_woff  out  OFFSET_WIDTH  cache line write word offset.
- line_wdata  out  32  cache line write data.
- line_wbe  out  4  cache line byte enable.
- line_wtag  out  TAG_WIDTH  cache line write tag.
- line_wdirty  out  1  cache line write dirty bit.
- line_wvalid  out  1  cache line write valid bit.
- line_roff  out  OFFSET_WIDTH  cache line read word offset.
- line_rdata  in  32  line word; 1-cycle synchronous read latency after line_roff.
- AXI read, fixed fields: arid=0, arsize=2, arburst=INCR, arlen=WORDS-1.
- AXI read, handshake/data: araddr out 32, arvalid out 1, arready in 1; rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.
- AXI write, fixed fields: awid=0, awsize=2, awburst=INCR, awlen=WORDS-1, wstrb=4'hF.
- AXI write, handshake/data: awaddr out 32, awvalid out 1, awready in 1; wdata out 32, wlast out 1, wvalid out 1, wready in 1; bresp in 2, bvalid in 1, bready out 1.

Behaviour:
- Reset (any time, including mid-burst):
  - State goes to IDLE; beat counter and err go to 0.
  - All valid/ready/we/done outputs go to 0; line_roff goes to 0.
  - Outstanding AXI traffic is abandoned.
- States: IDLE, WB_AW, WB_RD, WB_W, WB_B, RF_AR, RF_R, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr, victim_dirty and victim_tag, and clear beat and err.
  - Next state is WB_AW if victim_dirty, else RF_AR.
- WB_AW:
  - awaddr = {victim_tag, req_addr index, CACHE_LINE_WIDTH zeros}.
  - awvalid held until awready; then go to WB_RD.
- WB_RD:
  - line_roff=beat.
  - After one cycle go to WB_W (line_rdata is valid then).
- WB_W:
  - wvalid=1, wdata=line_rdata, wlast=(beat==WORDS-1); all held stable until wready.
  - On handshake: if last, go to WB_B; else beat+1 and go to WB_RD. Throughput is 2 cycles/beat.
- WB_B:
  - bready=1; on bvalid go to RF_AR with beat=0.
  - bresp!=0 sets err.
- RF_AR:
  - araddr = {req_addr[31:CACHE_LINE_WIDTH], zeros}.
  - arvalid held until arready; then go to RF_R.
- RF_R:
  - rready=1.
  - Each rvalid beat: line_we=1, line_woff=beat, line_wdata=rdata, line_wbe=4'hF, line_wtag=req tag, line_wdirty=0, line_wvalid=(beat==WORDS-1).
  - Beat increments with wrap; the line turns valid only on the final word.
  - Error conditions set err: rresp!=0, rlast on a non-final beat, or rlast missing on the final beat.
  - The final beat (counted, not rlast) goes to DONE.
- DONE:
  - done=1 for one cycle, err valid; then go to IDLE.
  - req_ready=0, so no request is accepted in this cycle.
- line_we is 0 outside RF_R handshake beats, so line_roff controls the storage during writeback.
- Beat counter is OFFSET_WIDTH bits and wraps at WORDS.

Optional Feature:
- CACHE_WB_PREFETCH_EN:
  - Defined: adds a 2-entry read-ahead buffer. line_roff runs one beat ahead and WB_RD is used only for beat 0, giving 1 beat/cycle under continuous wready. wdata order and wlast are unchanged.
  - Undefined: 2-cycle/beat behaviour above.

Decomposition:
- Shared package cache_pkg: CACHE_LINE_WIDTH, TAG_WIDTH, derived widths, AXI burst/size/resp constants, state encoding.
- One natural sub-module: cache_wb_buffer (read-ahead buffer, instantiated only under CACHE_WB_PREFETCH_EN).

Test Plan:
- Clean miss, req_addr=0x1234_5678, victim_dirty=0 -> araddr=0x1234_5640, arlen=15; 16 line_we pulses with woff 0..15; line_wvalid=1 only at woff 15, line_wtag=0x12345; done=1, err=0.
- Dirty miss, victim_tag=0xABCDE, index from 0x0000_0FC0, line words = offset*0x11111111 -> awaddr=0xABCDEFC0; 16 W beats with wdata=0x00000000..0xFFFFFFFF; wlast on beat 15; then refill.
- wready low 5 cycles on beat 3 -> wdata/wlast stable and no beat skipped or duplicated.
- rresp=2'b10 on beat 7 -> all 16 words still written; err=1 with done.
- rlast asserted on beat 9 -> err=1; done only after 16 beats.
- rst pulsed during WB_W beat 4 -> all outputs 0 immediately; a new request afterwards completes normally.
